dmem_bridge: RTL and testbench

Data-memory bridge between the MEM stage of the 5-stage MIPS pipeline and a variable-latency data memory bus. It takes the MEM-stage access (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`) and runs it as a req/ack bus transaction. It stalls the pipeline until the access completes, then returns registered read data on `mem_din` for the WB stage and the MEM-stage forward path. Misaligned and timed-out accesses are completed locally and flagged with sticky error bits.

---
 rtl/dmem_bridge.sv | 116 +++++++++++
 tb/tb_dmem_bridge.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns a MEM-stage load/store into a req/ack bus cycle,
// stalling the pipeline until it completes, with local error completion.
module dmem_bridge #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_ren_i,
    input  logic        mem_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_dout_i,
    output logic [31:0] mem_din_o,
    input  logic        pipe_adv_i,
    output logic        mem_stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        align_err_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;
    logic        align_err_q;
    logic        bus_err_q;
    logic [7:0]  wait_q;

    logic pending;
    logic misaligned;

    assign pending    = mem_ren_i | mem_wen_i;
    assign misaligned = (mem_addr_i[1:0] != 2'b00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
            wait_q      <= 8'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pending && misaligned) begin
                        align_err_q <= 1'b1;
                        rdata_q     <= ERR_DATA;
                        state_q     <= DONE;
                    end else if (pending) begin
                        bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
                        bus_wdata_q <= mem_dout_i;
                        // write wins when both strobes are high
                        bus_we_q    <= mem_wen_i;
                        bus_req_q   <= 1'b1;
                        wait_q      <= 8'h0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_ack_i) begin
                        bus_req_q <= 1'b0;
                        if (!bus_we_q) begin
                            rdata_q <= bus_rdata_i;
                        end
                        state_q <= DONE;
                    end else if (wait_q == LastWait) begin
                        bus_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        rdata_q   <= ERR_DATA;
                        state_q   <= DONE;
                    end else if (wait_q != 8'hFF) begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                DONE: begin
                    // frozen pipeline keeps the strobes high; never re-issue
                    if (pipe_adv_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_stall_o = ((state_q == IDLE) && pending) || (state_q == REQ);
    assign mem_din_o   = rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign align_err_o = align_err_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: transaction-timeline model plus per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_bridge;

    localparam int          TO  = 6;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_dout = '0;
    logic [31:0] mem_din;
    logic        pipe_adv = 1'b0;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        align_err;
    logic        bus_err;

    dmem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_ren_i(mem_ren), .mem_wen_i(mem_wen),
        .mem_addr_i(mem_addr), .mem_dout_i(mem_dout),
        .mem_din_o(mem_din), .pipe_adv_i(pipe_adv),
        .mem_stall_o(mem_stall),
        .bus_req_o(bus_req), .bus_we_o(bus_we),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack),
        .align_err_o(align_err), .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // architectural model state
    logic        m_we, m_aerr, m_berr;
    logic [31:0] m_addr, m_wd, m_din;

    // expectations for the current cycle
    bit          chk_en = 1'b0;
    logic        e_stall, e_req, e_we, e_aerr, e_berr;
    logic [31:0] e_addr, e_wd, e_din;
    int          stall_cnt = 0;
    int          req_cnt = 0;

    task automatic model_reset();
        m_we = 0; m_aerr = 0; m_berr = 0;
        m_addr = 0; m_wd = 0; m_din = 0;
    endtask

    task automatic load_exp(input logic stall, input logic req);
        e_stall = stall; e_req = req;
        e_we = m_we; e_addr = m_addr; e_wd = m_wd;
        e_din = m_din; e_aerr = m_aerr; e_berr = m_berr;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_stall", 32'(mem_stall), 32'(e_stall));
            chk("bus_req", 32'(bus_req), 32'(e_req));
            chk("bus_we", 32'(bus_we), 32'(e_we));
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_wdata", bus_wdata, e_wd);
            chk("mem_din", mem_din, e_din);
            chk("align_err", 32'(align_err), 32'(e_aerr));
            chk("bus_err", 32'(bus_err), 32'(e_berr));
        end
        if (mem_stall === 1'b1) stall_cnt++;
        if (bus_req === 1'b1) req_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access starting in an IDLE cycle. k = ack delay (0 = never),
    // hold = DONE cycles with pipe_adv low before advancing.
    task automatic do_access(input bit ren, input bit wen,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd, input int k,
                             input int hold);
        bit pend;
        bit acked;
        int n;
        pend = ren | wen;
        mem_ren = ren; mem_wen = wen; mem_addr = a; mem_dout = d;
        pipe_adv = 1'($urandom_range(0, 1));
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        load_exp(pend, 1'b0);
        step();
        if (!pend) return;
        if (a[1:0] != 2'b00) begin
            m_aerr = 1; m_din = ERR;
        end else begin
            m_addr = a; m_wd = d; m_we = wen;
            acked = (k >= 1 && k <= TO);
            n = acked ? k : TO;
            for (int i = 1; i <= n; i++) begin
                bus_ack = (i == k);
                bus_rdata = (i == k) ? rd : $urandom;
                pipe_adv = 1'($urandom_range(0, 1));
                load_exp(1'b1, 1'b1);
                step();
            end
            if (acked) begin
                if (!wen) m_din = rd;
            end else begin
                m_berr = 1; m_din = ERR;
            end
        end
        for (int i = 0; i <= hold; i++) begin
            pipe_adv = (i == hold);
            bus_ack = 1'b1;
            bus_rdata = $urandom;
            load_exp(1'b0, 1'b0);
            step();
        end
        mem_ren = 0; mem_wen = 0; bus_ack = 0; pipe_adv = 0;
        load_exp(1'b0, 1'b0);
    endtask

    task automatic clr_cnt();
        stall_cnt = 0;
        req_cnt = 0;
    endtask

    initial begin
        bit ren, wen;
        logic [31:0] a;
        rst = 1;
        step();
        model_reset();
        load_exp(1'b0, 1'b0);
        chk_en = 1;
        step();
        rst = 0;
        load_exp(1'b0, 1'b0);
        step();

        // read, ack in first REQ cycle
        clr_cnt();
        do_access(1, 0, 32'h10, 32'h0, 32'h1234_5678, 1, 0);
        chk("t1_din", mem_din, 32'h1234_5678);
        chk("t1_stall", 32'(stall_cnt), 32'd2);
        chk("t1_req", 32'(req_cnt), 32'd1);
        chk("t1_we", 32'(bus_we), 32'd0);

        // write, 5-cycle ack delay
        clr_cnt();
        do_access(0, 1, 32'h20, 32'hCAFE_F00D, 32'h5555_5555, 5, 0);
        chk("t2_stall", 32'(stall_cnt), 32'd6);
        chk("t2_req", 32'(req_cnt), 32'd5);
        chk("t2_we", 32'(bus_we), 32'd1);
        chk("t2_wdata", bus_wdata, 32'hCAFE_F00D);
        chk("t2_din", mem_din, 32'h1234_5678);

        // misaligned read, then a good access keeps the flag
        clr_cnt();
        do_access(1, 0, 32'h13, 32'h0, 32'h0, 1, 0);
        chk("t3_stall", 32'(stall_cnt), 32'd1);
        chk("t3_req", 32'(req_cnt), 32'd0);
        chk("t3_din", mem_din, ERR);
        do_access(1, 0, 32'h14, 32'h0, 32'hA5A5_0001, 2, 0);
        chk("t3_aerr", 32'(align_err), 32'd1);
        chk("t3_din2", mem_din, 32'hA5A5_0001);

        // timeout, with acks during DONE ignored
        clr_cnt();
        do_access(1, 0, 32'h30, 32'h0, 32'h0, 0, 2);
        chk("t4_req", 32'(req_cnt), 32'(TO));
        chk("t4_berr", 32'(bus_err), 32'd1);
        chk("t4_din", mem_din, ERR);

        // frozen DONE then back-to-back read
        clr_cnt();
        do_access(1, 0, 32'h50, 32'h0, 32'h0BAD_CAFE, 2, 3);
        chk("t5_req", 32'(req_cnt), 32'd2);
        chk("t5_stall", 32'(stall_cnt), 32'd3);
        clr_cnt();
        do_access(1, 0, 32'h54, 32'h0, 32'h600D_0054, 1, 0);
        chk("t5_req2", 32'(req_cnt), 32'd1);
        chk("t5_din", mem_din, 32'h600D_0054);

        // reset during REQ, coincident and late acks
        mem_ren = 1; mem_addr = 32'h40; mem_dout = 32'h77;
        load_exp(1'b1, 1'b0);
        step();
        m_addr = 32'h40; m_wd = 32'h77; m_we = 0;
        load_exp(1'b1, 1'b1);
        step();
        rst = 1; bus_ack = 1; bus_rdata = 32'hFFFF_0000;
        load_exp(1'b1, 1'b1);
        step();
        model_reset();
        rst = 0; mem_ren = 0;
        load_exp(1'b0, 1'b0);
        chk("t6_req", 32'(bus_req), 32'd0);
        chk("t6_din", mem_din, 32'h0);
        chk("t6_flags", {30'h0, align_err, bus_err}, 32'h0);
        step();
        bus_ack = 0;
        do_access(1, 1, 32'h60, 32'h1111_2222, 32'h0, 3, 1);
        chk("t6_we", 32'(bus_we), 32'd1);

        // randomized traffic
        for (int t = 0; t < 200; t++) begin
            ren = 1'($urandom_range(0, 1));
            wen = 1'($urandom_range(0, 1));
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_access(ren, wen, a, $urandom, $urandom,
                      $urandom_range(0, TO + 2), $urandom_range(0, 3));
        end

        step();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
